// File: rtl/can_framer_pkg.sv
// -----------------------------------------------------------------------------
// can_framer_pkg
// Shared definitions for can_rx_framer: FSM state encoding, header bit
// positions, packet byte offsets and a helper that XORs the four bytes of a
// zero-extended 29-bit CAN identifier.
// -----------------------------------------------------------------------------
package can_framer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SEND    = 2'd2
    } state_t;

    // Header byte layout: {ide, trunc, 2'b00, len[3:0]}
    localparam int HDR_IDE_BIT   = 7;
    localparam int HDR_TRUNC_BIT = 6;
    localparam int HDR_LEN_LSB   = 0;
    localparam int HDR_LEN_W     = 4;

    // Packet byte offsets
    localparam int OFS_SYNC = 0;
    localparam int OFS_HDR  = 1;
    localparam int OFS_ID   = 2;
    localparam int OFS_DATA = 6;

    localparam int ID_BYTES = 4;
    localparam int ID_W     = 29;

    // XOR of the four big-endian bytes of the zero-extended identifier.
    function automatic logic [7:0] id_xor(input logic [ID_W-1:0] id);
        logic [31:0] w;
        w = {3'b000, id};
        return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    endfunction

endpackage

// File: rtl/can_rx_framer.sv
// -----------------------------------------------------------------------------
// can_rx_framer
// Packs one received CAN frame (payload bytes + ID/IDE) into a self-delimiting
// byte packet for a byte sink such as a UART transmitter:
//   SYNC_BYTE, HDR={ide,trunc,2'b0,len}, ID[31:24..7:0], payload[0..len-1]
// Only one frame is held; frames completing while a packet is draining are
// discarded and counted in a saturating counter.
//
// Optional feature (macro CAN_FRAMER_CKSUM_EN): when defined, a trailing byte
// holding the XOR of every packet byte after SYNC_BYTE is appended.
//
// Ports
//   clk       in   system clock
//   rstn      in   asynchronous active-low reset
//   rx_valid  in   payload byte strobe (no backpressure)
//   rx_last   in   last byte of frame, qualified by rx_valid
//   rx_data   in   payload byte
//   rx_id     in   29-bit frame ID (11-bit IDs right-aligned)
//   rx_ide    in   1 = extended ID
//   o_valid   out  packet byte available
//   o_ready   in   sink accepts byte this cycle
//   o_data    out  packet byte
//   busy      out  framer not idle
//   drop_cnt  out  number of frames discarded (saturating)
// -----------------------------------------------------------------------------
module can_rx_framer
    import can_framer_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int         MAX_LEN    = 8,
    parameter int         DROP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  rx_valid,
    input  logic                  rx_last,
    input  logic [7:0]            rx_data,
    input  logic [28:0]           rx_id,
    input  logic                  rx_ide,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [7:0]            o_data,
    output logic                  busy,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

`ifdef CAN_FRAMER_CKSUM_EN
    localparam int CK_BYTES = 1;
`else
    localparam int CK_BYTES = 0;
`endif

    localparam int BUF_AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int PKT_W  = $clog2(OFS_DATA + MAX_LEN + CK_BYTES + 1);

    localparam logic [HDR_LEN_W-1:0] MAX_LEN_L = HDR_LEN_W'(MAX_LEN);
    localparam logic [PKT_W-1:0]     P_SYNC    = PKT_W'(OFS_SYNC);
    localparam logic [PKT_W-1:0]     P_HDR     = PKT_W'(OFS_HDR);
    localparam logic [PKT_W-1:0]     P_ID0     = PKT_W'(OFS_ID);
    localparam logic [PKT_W-1:0]     P_ID1     = PKT_W'(OFS_ID + 1);
    localparam logic [PKT_W-1:0]     P_ID2     = PKT_W'(OFS_ID + 2);
    localparam logic [PKT_W-1:0]     P_ID3     = PKT_W'(OFS_ID + 3);
    localparam logic [PKT_W-1:0]     P_DATA    = PKT_W'(OFS_DATA);

    state_t                 state, state_nxt;
    logic [ID_W-1:0]        id_q;
    logic                   ide_q;
    logic [7:0]             pay_q [MAX_LEN];
    logic [HDR_LEN_W-1:0]   len;
    logic                   trunc;
    logic [PKT_W-1:0]       idx;
    logic [PKT_W-1:0]       last_idx;
    logic [PKT_W-1:0]       data_ofs;
    logic [31:0]            id_ext;
    logic [7:0]             hdr;
    logic [7:0]             byte_sel;
    logic                   hs;
    logic                   at_last;
    logic                   first_acc;
    logic                   more_acc;
`ifdef CAN_FRAMER_CKSUM_EN
    logic [7:0]             ck_q;
`endif

    assign o_valid   = (state == SEND);
    assign busy      = (state != IDLE);
    assign o_data    = o_valid ? byte_sel : 8'h00;

    assign hs        = o_valid && o_ready;
    assign last_idx  = P_DATA + PKT_W'(len) - PKT_W'(1) + PKT_W'(CK_BYTES);
    assign at_last   = (idx == last_idx);
    assign first_acc = (state == IDLE) && rx_valid;
    // Bytes beyond MAX_LEN are discarded; only stored bytes enter the checksum.
    assign more_acc  = (state == COLLECT) && rx_valid && (len < MAX_LEN_L);
    assign id_ext    = {3'b000, id_q};

    always_comb begin
        hdr = 8'h00;
        hdr[HDR_IDE_BIT]   = ide_q;
        hdr[HDR_TRUNC_BIT] = trunc;
        hdr[HDR_LEN_LSB +: HDR_LEN_W] = len;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    state_nxt = rx_last ? SEND : COLLECT;
                end
            end
            COLLECT: begin
                if (rx_valid && rx_last) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (hs && at_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control: length, truncation flag, packet byte index, drop counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            len      <= '0;
            trunc    <= 1'b0;
            idx      <= '0;
            drop_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    idx <= '0;
                    if (rx_valid) begin
                        len   <= HDR_LEN_W'(1);
                        trunc <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (rx_valid) begin
                        if (len < MAX_LEN_L) begin
                            len <= len + HDR_LEN_W'(1);
                        end else begin
                            trunc <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    // The frame buffer is occupied for the whole SEND state,
                    // including the edge of the final handshake.
                    if (rx_valid && rx_last && !(&drop_cnt)) begin
                        drop_cnt <= drop_cnt + DROP_CNT_W'(1);
                    end
                    if (hs) begin
                        if (at_last) begin
                            idx   <= '0;
                            len   <= '0;
                            trunc <= 1'b0;
                        end else begin
                            idx <= idx + PKT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Frame payload, identifier and running checksum (data, not reset)
    always_ff @(posedge clk) begin
        if (first_acc) begin
            id_q     <= rx_id;
            ide_q    <= rx_ide;
            pay_q[0] <= rx_data;
        end else if (more_acc) begin
            pay_q[len[BUF_AW-1:0]] <= rx_data;
        end
    end

`ifdef CAN_FRAMER_CKSUM_EN
    always_ff @(posedge clk) begin
        if (first_acc) begin
            ck_q <= id_xor(rx_id) ^ rx_data;
        end else if (more_acc) begin
            ck_q <= ck_q ^ rx_data;
        end
    end
`endif

    // Packet byte select
    always_comb begin
        byte_sel = 8'h00;
        data_ofs = idx - P_DATA;
        case (idx)
            P_SYNC:  byte_sel = SYNC_BYTE;
            P_HDR:   byte_sel = hdr;
            P_ID0:   byte_sel = id_ext[31:24];
            P_ID1:   byte_sel = id_ext[23:16];
            P_ID2:   byte_sel = id_ext[15:8];
            P_ID3:   byte_sel = id_ext[7:0];
            default: begin
                if (data_ofs < PKT_W'(len)) begin
                    byte_sel = pay_q[data_ofs[BUF_AW-1:0]];
                end else begin
`ifdef CAN_FRAMER_CKSUM_EN
                    // Header is stable during SEND, so it is folded in here.
                    byte_sel = ck_q ^ hdr;
`else
                    byte_sel = 8'h00;
`endif
                end
            end
        endcase
    end

endmodule

// File: tb/tb_can_rx_framer.sv
module tb_can_rx_framer;

`ifdef CAN_FRAMER_CKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic        clk;
    logic        rstn;
    logic        rx_valid;
    logic        rx_last;
    logic [7:0]  rx_data;
    logic [28:0] rx_id;
    logic        rx_ide;
    logic        o_valid;
    logic        o_ready;
    logic [7:0]  o_data;
    logic        busy;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    can_rx_framer dut (
        .clk      (clk),
        .rstn     (rstn),
        .rx_valid (rx_valid),
        .rx_last  (rx_last),
        .rx_data  (rx_data),
        .rx_id    (rx_id),
        .rx_ide   (rx_ide),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .o_data   (o_data),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [28:0] id;
        logic        ide;
        int          n;
        logic [7:0]  d [10];
        int          en;
        logic [7:0]  e [16];
        logic [7:0]  ck;
        int          mode;   // 0: o_ready always high, 1: high one cycle in three
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input int vi);
        for (int i = 0; i < vecs[vi].n; i++) begin
            rx_valid = 1'b1;
            rx_id    = vecs[vi].id;
            rx_ide   = vecs[vi].ide;
            rx_data  = vecs[vi].d[i];
            rx_last  = (i == vecs[vi].n - 1);
            @(posedge clk); #1;
            if (i != vecs[vi].n - 1) begin
                chk("busy_collect", busy, 1);
                chk("o_valid_collect", o_valid, 0);
            end
        end
        rx_valid = 1'b0;
        rx_last  = 1'b0;
    endtask

    task automatic drain(input int vi, input int mode, input int stop_at);
        int k = 0;
        int cyc = 0;
        int total;
        logic [7:0] ex;
        total = vecs[vi].en + CK;
        while (k < total && k != stop_at && cyc < 200) begin
            o_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 2);
            ex = (k < vecs[vi].en) ? vecs[vi].e[k] : vecs[vi].ck;
            chk("o_valid_drain", o_valid, 1);
            chk($sformatf("v%0d_byte%0d", vi, k), o_data, ex);
            if (o_valid && o_ready) k++;
            cyc++;
            @(posedge clk); #1;
        end
        o_ready = 1'b0;
        if (k != total && k != stop_at) chk("drain_timeout", k, total);
    endtask

    initial begin
        vecs[0].id = 29'h123; vecs[0].ide = 1'b0; vecs[0].n = 3; vecs[0].mode = 0;
        vecs[0].d  = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[0].en = 9; vecs[0].ck = 8'h21;
        vecs[0].e  = '{8'hA5, 8'h03, 8'h00, 8'h00, 8'h01, 8'h23, 8'h11, 8'h22,
                       8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        vecs[1].id = 29'h12345678; vecs[1].ide = 1'b1; vecs[1].n = 8; vecs[1].mode = 0;
        vecs[1].d  = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h00, 8'h00};
        vecs[1].en = 14; vecs[1].ck = 8'h80;
        vecs[1].e  = '{8'hA5, 8'h88, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h01,
                       8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h00, 8'h00};

        vecs[2].id = 29'h7FF; vecs[2].ide = 1'b0; vecs[2].n = 10; vecs[2].mode = 1;
        vecs[2].d  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
        vecs[2].en = 14; vecs[2].ck = 8'hB8;
        vecs[2].e  = '{8'hA5, 8'h48, 8'h00, 8'h00, 8'h07, 8'hFF, 8'h01, 8'h02,
                       8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h00, 8'h00};

        vecs[3].id = 29'h0; vecs[3].ide = 1'b0; vecs[3].n = 1; vecs[3].mode = 0;
        vecs[3].d  = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[3].en = 7; vecs[3].ck = 8'h5B;
        vecs[3].e  = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5A, 8'h00,
                       8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        rstn = 1'b0; rx_valid = 1'b0; rx_last = 1'b0; rx_data = 8'h00;
        rx_id = 29'h0; rx_ide = 1'b0; o_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_data", o_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Table-driven packets
        for (int vi = 0; vi < 4; vi++) begin
            send_frame(vi);
            chk("latency_o_valid", o_valid, 1);
            chk("latency_sync", o_data, 8'hA5);
            drain(vi, vecs[vi].mode, -1);
            chk("end_o_valid", o_valid, 0);
            chk("end_busy", busy, 0);
            @(posedge clk); #1;
        end
        chk("drop_cnt_none", drop_cnt, 0);

        // Second frame arrives while the first drains
        send_frame(0);
        fork
            drain(0, 1, -1);
            begin
                repeat (3) @(posedge clk);
                #1;
                send_frame(3);
            end
        join
        chk("drop_cnt_one", drop_cnt, 1);
        for (int i = 0; i < 5; i++) begin
            chk("no_second_pkt", o_valid, 0);
            @(posedge clk); #1;
        end

        // Drop counter saturation: hold a completing frame while SEND stalls
        o_ready  = 1'b0;
        rx_id    = vecs[3].id;
        rx_ide   = vecs[3].ide;
        rx_data  = vecs[3].d[0];
        rx_valid = 1'b1;
        rx_last  = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        chk("drop_cnt_sat", drop_cnt, 16'hFFFF);
        drain(3, 0, -1);
        chk("drop_cnt_sat_hold", drop_cnt, 16'hFFFF);
        chk("sat_end_busy", busy, 0);

        // Reset in the middle of a packet
        send_frame(0);
        drain(0, 0, 4);
        chk("mid_byte4", o_data, vecs[0].e[4]);
        rstn = 1'b0;
        #1;
        chk("mid_rst_o_valid", o_valid, 0);
        chk("mid_rst_o_data", o_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_drop_cnt", drop_cnt, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        send_frame(0);
        chk("post_rst_sync", o_data, 8'hA5);
        drain(0, 0, -1);
        chk("post_rst_end_o_valid", o_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
